instruction_encoder: RTL and testbench

Packs decoded instruction fields (ALU op code, destination, source, immediate) into the 32-bit IR word stream consumed by InstructionDecoder. It feeds the instruction memory loader and decoder test stimulus. Small immediates are folded into the instruction word. Immediates that do not fit are emitted as a second, full 32-bit word. Field-level valid/ready handshake on the input, word-level valid/ready on the output, with one registered output stage.

---
 rtl/instruction_encoder.sv | 132 +++++++++++++
 tb/tb_instruction_encoder.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_encoder.sv
// Instruction encoder: packs op/dst/src/immediate fields into 32-bit IR words.
// Immediates that fit in a signed 16-bit field are folded into the IR word;
// others set the ext flag and follow as a second, full 32-bit word.
module instruction_encoder #(
   parameter int unsigned SHORT_IMM_WIDTH = 16,
   parameter int unsigned COUNT_WIDTH     = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   inValid,
   output logic                   inReady,
   input  logic [3:0]             ALUOperationCode,
   input  logic [4:0]             destination,
   input  logic [4:0]             source,
   input  logic                   isSecondImmediate,
   input  logic [31:0]            immediate,
   output logic                   outValid,
   input  logic                   outReady,
   output logic [31:0]            outWord,
   output logic                   outIsExtension,
   output logic [COUNT_WIDTH-1:0] instructionCount,
   output logic [COUNT_WIDTH-1:0] wordCount
);

   typedef enum logic [1:0] {StIdle, StFirst, StSecond} state_e;

   localparam int unsigned ExtBit = SHORT_IMM_WIDTH;

   state_e                 r_state_q, w_state_d;
   logic                   r_out_valid_q, w_out_valid_d;
   logic [31:0]            r_out_word_q, w_out_word_d;
   logic                   r_out_ext_q, w_out_ext_d;
   logic [31:0]            r_hold_q, w_hold_d;
   logic [COUNT_WIDTH-1:0] r_instr_count_q, r_word_count_q;

   logic        w_fits;
   logic        w_needs_ext;
   logic [31:0] w_instr_word;
   logic        w_accept;
   logic        w_handoff;

   // Fit: bits above the sign bit of the short field all match the sign bit.
   assign w_fits      = (&immediate[31:SHORT_IMM_WIDTH-1]) || ~(|immediate[31:SHORT_IMM_WIDTH-1]);
   assign w_needs_ext = isSecondImmediate && !w_fits;

   // Build the IR word from the input fields.
   always_comb begin
      w_instr_word        = '0;
      w_instr_word[31:28] = ALUOperationCode;
      w_instr_word[27:23] = destination;
      w_instr_word[22:18] = source;
      w_instr_word[17]    = isSecondImmediate;
      w_instr_word[16]    = w_needs_ext;
      if (isSecondImmediate && w_fits) begin
         w_instr_word[SHORT_IMM_WIDTH-1:0] = immediate[SHORT_IMM_WIDTH-1:0];
      end
   end

   // A pending ext flag in FIRST blocks new input until the extension word is out.
   assign inReady = reset && ((r_state_q == StIdle) ||
                              ((r_state_q == StFirst) && !r_out_word_q[ExtBit] && outReady) ||
                              ((r_state_q == StSecond) && outReady));

   assign w_accept  = inValid && inReady;
   assign w_handoff = r_out_valid_q && outReady;

   // Next-state and output-stage update; a new accept overrides the drain path.
   always_comb begin
      w_state_d     = r_state_q;
      w_out_valid_d = r_out_valid_q;
      w_out_word_d  = r_out_word_q;
      w_out_ext_d   = r_out_ext_q;
      w_hold_d      = r_hold_q;
      if (w_accept) begin
         w_state_d     = StFirst;
         w_out_valid_d = 1'b1;
         w_out_word_d  = w_instr_word;
         w_out_ext_d   = 1'b0;
         w_hold_d      = immediate;
      end else begin
         unique case (r_state_q)
            StFirst: begin
               if (outReady) begin
                  if (r_out_word_q[ExtBit]) begin
                     w_state_d    = StSecond;
                     w_out_word_d = r_hold_q;
                     w_out_ext_d  = 1'b1;
                  end else begin
                     w_state_d     = StIdle;
                     w_out_valid_d = 1'b0;
                  end
               end
            end
            StSecond: begin
               if (outReady) begin
                  w_state_d     = StIdle;
                  w_out_valid_d = 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // State, output stage, hold register and statistics counters.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state_q       <= StIdle;
         r_out_valid_q   <= 1'b0;
         r_out_word_q    <= '0;
         r_out_ext_q     <= 1'b0;
         r_hold_q        <= '0;
         r_instr_count_q <= '0;
         r_word_count_q  <= '0;
      end else begin
         r_state_q     <= w_state_d;
         r_out_valid_q <= w_out_valid_d;
         r_out_word_q  <= w_out_word_d;
         r_out_ext_q   <= w_out_ext_d;
         r_hold_q      <= w_hold_d;
         if (w_accept) r_instr_count_q <= r_instr_count_q + COUNT_WIDTH'(1);
         if (w_handoff) r_word_count_q <= r_word_count_q + COUNT_WIDTH'(1);
      end
   end

   assign outValid         = r_out_valid_q;
   assign outWord          = r_out_word_q;
   assign outIsExtension   = r_out_ext_q;
   assign instructionCount = r_instr_count_q;
   assign wordCount        = r_word_count_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder; inputs driven and outputs sampled on negedge.
module tb_instruction_encoder;

   logic        clock;
   logic        reset;
   logic        inValid;
   logic        inReady;
   logic [3:0]  op;
   logic [4:0]  dst;
   logic [4:0]  src;
   logic        is_imm;
   logic [31:0] imm;
   logic        outValid;
   logic        outReady;
   logic [31:0] outWord;
   logic        outIsExtension;
   logic [15:0] instructionCount;
   logic [15:0] wordCount;

   int n_tests = 0;
   int n_fail  = 0;

   instruction_encoder #(
      .SHORT_IMM_WIDTH(16),
      .COUNT_WIDTH(16)
   ) dut (
      .clock(clock),
      .reset(reset),
      .inValid(inValid),
      .inReady(inReady),
      .ALUOperationCode(op),
      .destination(dst),
      .source(src),
      .isSecondImmediate(is_imm),
      .immediate(imm),
      .outValid(outValid),
      .outReady(outReady),
      .outWord(outWord),
      .outIsExtension(outIsExtension),
      .instructionCount(instructionCount),
      .wordCount(wordCount)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic drive(input logic [3:0] o, input logic [4:0] d, input logic [4:0] s,
                        input logic i, input logic [31:0] v);
      inValid = 1'b1;
      op = o; dst = d; src = s; is_imm = i; imm = v;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b0; inValid = 1'b0;
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0; inValid = 1'b0; outReady = 1'b1;
      op = '0; dst = '0; src = '0; is_imm = 1'b0; imm = '0;
      @(negedge clock);
      @(negedge clock);
      n_tests++;
      if (outValid !== 1'b0 || outWord !== 32'h0 || outIsExtension !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_out got v=%b w=%h x=%b exp v=0 w=0 x=0",
                  outValid, outWord, outIsExtension);
      end
      n_tests++;
      if (instructionCount !== 16'd0 || wordCount !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_counts got ic=%0d wc=%0d exp 0 0", instructionCount, wordCount);
      end
      n_tests++;
      if (inReady !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_inready_low got %b exp 0", inReady);
      end
      reset = 1'b1;
      #1;
      n_tests++;
      if (inReady !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_inready_high got %b exp 1", inReady);
      end
   endtask

   task automatic test_register_op();
      @(negedge clock);
      drive(4'h3, 5'd1, 5'd2, 1'b0, 32'hDEADBEEF);
      @(negedge clock);
      inValid = 1'b0;
      n_tests++;
      if (outValid !== 1'b1 || outWord !== 32'h30880000 || outIsExtension !== 1'b0) begin
         n_fail++;
         $display("FAIL regop_word got v=%b w=%h x=%b exp v=1 w=30880000 x=0",
                  outValid, outWord, outIsExtension);
      end
      n_tests++;
      if (instructionCount !== 16'd1) begin
         n_fail++;
         $display("FAIL regop_icount got %0d exp 1", instructionCount);
      end
      @(negedge clock);
      n_tests++;
      if (outValid !== 1'b0 || wordCount !== 16'd1) begin
         n_fail++;
         $display("FAIL regop_done got v=%b wc=%0d exp v=0 wc=1", outValid, wordCount);
      end
   endtask

   task automatic test_short_imm();
      @(negedge clock);
      drive(4'hA, 5'd5, 5'd0, 1'b1, 32'hFFFFFFFE);
      @(negedge clock);
      inValid = 1'b0;
      n_tests++;
      if (outValid !== 1'b1 || outWord !== 32'hA282FFFE || outIsExtension !== 1'b0) begin
         n_fail++;
         $display("FAIL short_word got v=%b w=%h x=%b exp v=1 w=a282fffe x=0",
                  outValid, outWord, outIsExtension);
      end
      @(negedge clock);
      n_tests++;
      if (outValid !== 1'b0) begin
         n_fail++;
         $display("FAIL short_single got v=%b exp 0", outValid);
      end
      drive(4'hA, 5'd5, 5'd0, 1'b1, 32'hFFFF8000);
      @(negedge clock);
      inValid = 1'b0;
      n_tests++;
      if (outWord !== 32'hA2828000 || outIsExtension !== 1'b0) begin
         n_fail++;
         $display("FAIL short_boundary got w=%h x=%b exp w=a2828000 x=0",
                  outWord, outIsExtension);
      end
      @(negedge clock);
      n_tests++;
      if (outValid !== 1'b0 || instructionCount !== 16'd3 || wordCount !== 16'd3) begin
         n_fail++;
         $display("FAIL short_done got v=%b ic=%0d wc=%0d exp v=0 ic=3 wc=3",
                  outValid, instructionCount, wordCount);
      end
   endtask

   task automatic test_long_imm();
      logic [31:0] vals [2];
      vals[0] = 32'h12345678;
      vals[1] = 32'h00008000;
      for (int k = 0; k < 2; k++) begin
         @(negedge clock);
         drive(4'h1, 5'd31, 5'd0, 1'b1, vals[k]);
         @(negedge clock);
         inValid = 1'b0;
         n_tests++;
         if (outValid !== 1'b1 || outWord !== 32'h1F830000 || outIsExtension !== 1'b0) begin
            n_fail++;
            $display("FAIL long_first[%0d] got v=%b w=%h x=%b exp v=1 w=1f830000 x=0",
                     k, outValid, outWord, outIsExtension);
         end
         n_tests++;
         if (inReady !== 1'b0) begin
            n_fail++;
            $display("FAIL long_inready[%0d] got %b exp 0", k, inReady);
         end
         @(negedge clock);
         n_tests++;
         if (outValid !== 1'b1 || outWord !== vals[k] || outIsExtension !== 1'b1) begin
            n_fail++;
            $display("FAIL long_ext[%0d] got v=%b w=%h x=%b exp v=1 w=%h x=1",
                     k, outValid, outWord, outIsExtension, vals[k]);
         end
         @(negedge clock);
         n_tests++;
         if (outValid !== 1'b0) begin
            n_fail++;
            $display("FAIL long_idle[%0d] got v=%b exp 0", k, outValid);
         end
      end
      n_tests++;
      if (instructionCount !== 16'd5 || wordCount !== 16'd7) begin
         n_fail++;
         $display("FAIL long_counts got ic=%0d wc=%0d exp ic=5 wc=7",
                  instructionCount, wordCount);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_w [3];
      exp_w[0] = 32'h21900000;
      exp_w[1] = 32'h40060007;
      exp_w[2] = 32'hFFFE8001;
      do_reset();
      outReady = 1'b1;
      drive(4'h2, 5'd3, 5'd4, 1'b0, 32'h0);
      @(negedge clock);
      n_tests++;
      if (outWord !== exp_w[0] || inReady !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_0 got w=%h rdy=%b exp w=%h rdy=1", outWord, inReady, exp_w[0]);
      end
      drive(4'h4, 5'd0, 5'd1, 1'b1, 32'h7);
      @(negedge clock);
      n_tests++;
      if (outWord !== exp_w[1] || inReady !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_1 got w=%h rdy=%b exp w=%h rdy=1", outWord, inReady, exp_w[1]);
      end
      drive(4'hF, 5'd31, 5'd31, 1'b1, 32'hFFFF8001);
      @(negedge clock);
      inValid = 1'b0;
      n_tests++;
      if (outWord !== exp_w[2] || outValid !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_2 got w=%h v=%b exp w=%h v=1", outWord, outValid, exp_w[2]);
      end
      @(negedge clock);
      n_tests++;
      if (outValid !== 1'b0 || wordCount !== 16'd3 || instructionCount !== 16'd3) begin
         n_fail++;
         $display("FAIL b2b_done got v=%b wc=%0d ic=%0d exp v=0 wc=3 ic=3",
                  outValid, wordCount, instructionCount);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      outReady = 1'b0;
      drive(4'h1, 5'd31, 5'd0, 1'b1, 32'h12345678);
      @(negedge clock);
      inValid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         n_tests++;
         if (outValid !== 1'b1 || outWord !== 32'h1F830000 || outIsExtension !== 1'b0 ||
             inReady !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold[%0d] got v=%b w=%h x=%b rdy=%b exp v=1 w=1f830000 x=0 rdy=0",
                     c, outValid, outWord, outIsExtension, inReady);
         end
         @(negedge clock);
      end
      outReady = 1'b1;
      @(negedge clock);
      n_tests++;
      if (outValid !== 1'b1 || outWord !== 32'h12345678 || outIsExtension !== 1'b1 ||
          inReady !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_ext got v=%b w=%h x=%b rdy=%b exp v=1 w=12345678 x=1 rdy=1",
                  outValid, outWord, outIsExtension, inReady);
      end
      @(negedge clock);
      n_tests++;
      if (outValid !== 1'b0 || wordCount !== 16'd2 || instructionCount !== 16'd1) begin
         n_fail++;
         $display("FAIL bp_done got v=%b wc=%0d ic=%0d exp v=0 wc=2 ic=1",
                  outValid, wordCount, instructionCount);
      end
   endtask

   task automatic test_reset_in_second();
      do_reset();
      outReady = 1'b1;
      drive(4'h1, 5'd31, 5'd0, 1'b1, 32'h12345678);
      @(negedge clock);
      inValid = 1'b0;
      @(negedge clock);
      n_tests++;
      if (outIsExtension !== 1'b1 || outValid !== 1'b1) begin
         n_fail++;
         $display("FAIL rst2_pre got x=%b v=%b exp x=1 v=1", outIsExtension, outValid);
      end
      reset = 1'b0;
      #1;
      n_tests++;
      if (inReady !== 1'b0) begin
         n_fail++;
         $display("FAIL rst2_inready_low got %b exp 0", inReady);
      end
      @(negedge clock);
      reset = 1'b1;
      #1;
      n_tests++;
      if (outValid !== 1'b0 || outIsExtension !== 1'b0 || instructionCount !== 16'd0 ||
          wordCount !== 16'd0 || inReady !== 1'b1) begin
         n_fail++;
         $display("FAIL rst2_post got v=%b x=%b ic=%0d wc=%0d rdy=%b exp v=0 x=0 ic=0 wc=0 rdy=1",
                  outValid, outIsExtension, instructionCount, wordCount, inReady);
      end
      @(negedge clock);
      n_tests++;
      if (outValid !== 1'b0) begin
         n_fail++;
         $display("FAIL rst2_no_ext got v=%b exp 0", outValid);
      end
   endtask

   initial begin
      test_reset();
      test_register_op();
      test_short_imm();
      test_long_imm();
      test_back_to_back();
      test_backpressure();
      test_reset_in_second();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
